fifo_stream_reader: RTL

Read-side adapter that sits directly downstream of the team's synchronous FIFO (sync_fifo: registered data_out, one-cycle read latency, full/empty flags). It drains the FIFO through its rd_en/empty/data_out interface. It presents the words on a valid/ready stream with a 2-entry holding buffer, so backpressure never loses the in-flight read. It groups words into fixed-length packets and marks the final beat with m_last.

---
 rtl/fifo_stream_reader.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
//   Drains the upstream sync_fifo through its rd_en/empty/data_out interface.
//   The FIFO has a one-cycle read latency. Every word that is read lands in a
//   2-entry holding buffer. Because of that buffer, downstream backpressure
//   never drops a read that is already in flight. Words are sent out on a
//   valid/ready stream and grouped into packets of PKT_LEN beats. m_last marks
//   the final beat of each packet.
//
//   Optional feature: FIFO_STREAM_CHECKSUM_EN
//     When defined, each packet is followed by one extra beat. That beat
//     carries the modulo-2^WIDTH sum of the packet's payload words, and m_last
//     is asserted only on it. When undefined, no checksum logic is built.
//
// Ports
//   clk         clock, all state changes on the rising edge
//   rst_n       synchronous active-low reset
//   fifo_empty  upstream FIFO empty flag
//   fifo_data   upstream FIFO data_out, valid the cycle after an accepted read
//   fifo_rd_en  read request to the upstream FIFO
//   m_valid     stream data valid
//   m_ready     downstream ready
//   m_data      stream data
//   m_last      final beat of a packet
module fifo_stream_reader #(
    parameter int WIDTH   = 8,
    parameter int PKT_LEN = 4,
    parameter int CNT_W   = $clog2(PKT_LEN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             fifo_rd_en,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last
);

    // Holding buffer: hold0 is always the head and hold1 the second entry.
    logic [WIDTH-1:0] hold0;
    logic [WIDTH-1:0] hold1;
    logic [1:0]       count;
    logic             inflight;
    logic [CNT_W-1:0] beat_cnt;

    logic             wr;
    logic             pop;
    logic             has_word;
    logic             beat_end;
    logic [2:0]       occupancy;

    assign wr       = inflight;
    assign has_word = (count != 2'd0);
    assign beat_end = (beat_cnt == CNT_W'(PKT_LEN - 1));

    // A new read is issued only when the slot it will land in is guaranteed.
    // That holds when buffered + in-flight words, minus the word leaving this
    // cycle, stay below the buffer depth.
    assign occupancy  = 3'(count) + 3'(inflight);
    assign fifo_rd_en = rst_n && !fifo_empty && (occupancy < (3'd2 + 3'(pop)));

`ifdef FIFO_STREAM_CHECKSUM_EN

    typedef enum logic {
        PAYLOAD = 1'b0,
        CKSUM   = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             in_cksum;
    logic [WIDTH-1:0] checksum;

    function automatic logic [WIDTH-1:0] wrap_add(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        return a + b;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= PAYLOAD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_cksum   = 1'b0;
        case (state)
            PAYLOAD: begin
                if (pop && beat_end) begin
                    state_next = CKSUM;
                end
            end
            CKSUM: begin
                in_cksum = 1'b1;
                if (m_ready) begin
                    state_next = PAYLOAD;
                end
            end
            default: state_next = PAYLOAD;
        endcase
    end

    // The checksum beat does not touch the buffer. Reads keep filling it.
    assign pop     = !in_cksum && has_word && m_ready;
    assign m_valid = in_cksum || has_word;
    assign m_data  = in_cksum ? checksum : (has_word ? hold0 : '0);
    assign m_last  = in_cksum;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_cnt <= '0;
            checksum <= '0;
        end else if (in_cksum && m_ready) begin
            beat_cnt <= '0;
            checksum <= '0;
        end else if (pop) begin
            checksum <= wrap_add(checksum, hold0);
            // Hold at the final index until the checksum beat is accepted.
            if (!beat_end) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

`else

    assign pop     = has_word && m_ready;
    assign m_valid = has_word;
    assign m_data  = has_word ? hold0 : '0;
    assign m_last  = has_word && beat_end;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_cnt <= '0;
        end else if (pop) begin
            beat_cnt <= beat_end ? '0 : beat_cnt + 1'b1;
        end
    end

`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inflight <= 1'b0;
            count    <= 2'd0;
        end else begin
            inflight <= fifo_rd_en;
            case ({wr, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Buffer storage is not reset. count alone decides which entries are live.
    always_ff @(posedge clk) begin
        case ({wr, pop})
            2'b10: begin
                if (count == 2'd0) begin
                    hold0 <= fifo_data;
                end else begin
                    hold1 <= fifo_data;
                end
            end
            2'b01: begin
                hold0 <= hold1;
            end
            2'b11: begin
                if (count == 2'd1) begin
                    hold0 <= fifo_data;
                end else begin
                    hold0 <= hold1;
                    hold1 <= fifo_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(wr && !pop && (count == 2'd2)));
            assert (count != 2'd3);
        end
    end

endmodule
